// File: rtl/rr_arbitrated_fifos_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbitrated_fifos_if
// Purpose  : Bundle of the producer-side and consumer-side signals of the
//            round-robin arbitrated FIFO block.
// Ports    : push / flat_data_in        per-channel write strobes and data
//            full / empty               per-channel FIFO status
//            out_vld / out_rdy          output valid/ready handshake
//            data_out / out_tag         output entry and its source channel
//            gnt                        one-hot pop strobe
//            err_ovf                    sticky overflow flag
// Modports : master - environment side (drives push, data, out_rdy)
//            slave  - the arbitrated FIFO block itself
// Revision : 1.0 - initial release
// ============================================================================
interface rr_arbitrated_fifos_if #(
    parameter int NUM_FIFOS = 4,
    parameter int WIDTH     = 8,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
);
    logic [NUM_FIFOS-1:0]       push;
    logic [NUM_FIFOS*WIDTH-1:0] flat_data_in;
    logic [NUM_FIFOS-1:0]       full;
    logic [NUM_FIFOS-1:0]       empty;
    logic                       out_vld;
    logic                       out_rdy;
    logic [WIDTH-1:0]           data_out;
    logic [TAGWIDTH-1:0]        out_tag;
    logic [NUM_FIFOS-1:0]       gnt;
    logic                       err_ovf;

    modport master (
        output push,
        output flat_data_in,
        output out_rdy,
        input  full,
        input  empty,
        input  out_vld,
        input  data_out,
        input  out_tag,
        input  gnt,
        input  err_ovf
    );

    modport slave (
        input  push,
        input  flat_data_in,
        input  out_rdy,
        output full,
        output empty,
        output out_vld,
        output data_out,
        output out_tag,
        output gnt,
        output err_ovf
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbitrated_fifos.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbitrated_fifos
// Purpose  : N-channel input buffer. Every channel owns a circular,
//            count-based FIFO; a round-robin arbiter drains the FIFOs onto a
//            single valid/ready output and tags each entry with its source.
// Ports    : clk        single clock, all logic on posedge
//            rst        synchronous active-high reset
//            bus        rr_arbitrated_fifos_if.slave
//              push[N]         per-channel write strobe
//              flat_data_in    channel i at [(i+1)*WIDTH-1 : i*WIDTH]
//              full[N]/empty[N] per-channel status
//              out_vld/out_rdy output handshake
//              data_out        selected entry (0 when not valid)
//              out_tag         source channel of data_out (0 when not valid)
//              gnt[N]          one-hot pop strobe
//              err_ovf         sticky: push seen on a full channel
// Config   : OUT_REG_EN  when defined, a one-entry output register (oreg)
//            sits between the arbiter and the output; the oreg load is the
//            pop. When undefined the output is combinational from the heads.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbitrated_fifos #(
    parameter int NUM_FIFOS = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    rr_arbitrated_fifos_if.slave bus
);

    localparam int                  c_PTR_W = $clog2(DEPTH);
    localparam int                  c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [TAGWIDTH-1:0] c_LAST  = TAGWIDTH'(NUM_FIFOS - 1);

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]     r_mem   [NUM_FIFOS][DEPTH];
    logic [c_PTR_W-1:0]   r_wptr  [NUM_FIFOS];
    logic [c_PTR_W-1:0]   r_rptr  [NUM_FIFOS];
    logic [c_CNT_W-1:0]   r_count [NUM_FIFOS];
    logic [WIDTH-1:0]     w_head  [NUM_FIFOS];

    logic [NUM_FIFOS-1:0] w_full;
    logic [NUM_FIFOS-1:0] w_empty;
    logic [NUM_FIFOS-1:0] w_wr;
    logic [NUM_FIFOS-1:0] w_pop;

    // Arbitration
    logic [TAGWIDTH-1:0]  r_rr;
    logic [TAGWIDTH-1:0]  w_search;
    logic [TAGWIDTH-1:0]  w_sel;
    logic                 w_any;
    logic                 w_take;

    logic                 r_err_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIFOS; gi++) begin : g_fifo
            assign w_full[gi]  = (r_count[gi] == c_DEPTH);
            assign w_empty[gi] = (r_count[gi] == '0);
            // A push into a full channel is dropped even if that channel
            // pops in the same cycle.
            assign w_wr[gi]    = bus.push[gi] & ~w_full[gi];
            assign w_head[gi]  = r_mem[gi][r_rptr[gi]];
        end
    endgenerate

    assign bus.full  = w_full;
    assign bus.empty = w_empty;
    assign w_any     = ~&w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                r_wptr[i]  <= '0;
                r_rptr[i]  <= '0;
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                if (w_wr[i]) begin
                    r_wptr[i] <= r_wptr[i] + c_PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + c_PTR_W'(1);
                end
                // Simultaneous write and pop leaves the count unchanged,
                // including the pop-to-empty case where the new entry stays.
                case ({w_wr[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + c_CNT_W'(1);
                    2'b01:   r_count[i] <= r_count[i] - c_CNT_W'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // Entry storage carries no reset; stale words are unreachable once the
    // pointers and counts are cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (w_wr[i]) begin
                r_mem[i][r_wptr[i]] <= bus.flat_data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin search: priority rr, rr+1, ..., NUM_FIFOS-1, 0, ..., rr-1
    // ------------------------------------------------------------------
    always_comb begin
        int   w_idx;
        logic w_found;
        w_search = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NUM_FIFOS; k++) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= NUM_FIFOS) begin
                w_idx = w_idx - NUM_FIFOS;
            end
            if (!w_found && !w_empty[w_idx]) begin
                w_found  = 1'b1;
                w_search = TAGWIDTH'(w_idx);
            end
        end
    end

    // One-hot pop strobe for the selected channel
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            w_pop[i] = w_take && (w_sel == TAGWIDTH'(i));
        end
    end

    assign bus.gnt = w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= '0;
        end else if (w_take) begin
            r_rr <= (w_sel == c_LAST) ? '0 : w_sel + TAGWIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output path
    // ------------------------------------------------------------------
`ifdef OUT_REG_EN
    logic                r_oreg_vld;
    logic [WIDTH-1:0]    r_oreg_data;
    logic [TAGWIDTH-1:0] r_oreg_tag;

    assign w_sel  = w_search;
    // The oreg load is the pop; it refills in the same cycle the consumer
    // takes the current entry, keeping one entry per cycle.
    assign w_take = w_any & (~r_oreg_vld | bus.out_rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_oreg_vld  <= 1'b0;
            r_oreg_data <= '0;
            r_oreg_tag  <= '0;
        end else if (w_take) begin
            r_oreg_vld  <= 1'b1;
            r_oreg_data <= w_head[w_sel];
            r_oreg_tag  <= w_sel;
        end else if (bus.out_rdy) begin
            r_oreg_vld  <= 1'b0;
            r_oreg_data <= '0;
            r_oreg_tag  <= '0;
        end
    end

    assign bus.out_vld  = r_oreg_vld;
    assign bus.data_out = r_oreg_data;
    assign bus.out_tag  = r_oreg_tag;
`else
    // While the consumer stalls, the selection is frozen so that a push into
    // a higher-priority empty channel cannot swap the presented entry. The
    // locked channel cannot drain meanwhile because no pop occurs.
    logic                r_lock;
    logic [TAGWIDTH-1:0] r_lock_sel;

    assign w_sel  = r_lock ? r_lock_sel : w_search;
    assign w_take = w_any & bus.out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock     <= 1'b0;
            r_lock_sel <= '0;
        end else begin
            r_lock     <= w_any & ~bus.out_rdy;
            r_lock_sel <= w_sel;
        end
    end

    assign bus.out_vld  = w_any;
    assign bus.data_out = w_any ? w_head[w_sel] : '0;
    assign bus.out_tag  = w_any ? w_sel : '0;
`endif

    // ------------------------------------------------------------------
    // Sticky overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_ovf <= 1'b0;
        end else if (|(bus.push & w_full)) begin
            r_err_ovf <= 1'b1;
        end
    end

    assign bus.err_ovf = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbitrated_fifos.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbitrated_fifos
// Purpose  : Directed self-checking bench for rr_arbitrated_fifos
//            (NUM_FIFOS=4, WIDTH=8, DEPTH=4). Inputs change on the falling
//            edge; a monitor records every output transfer and every grant
//            just before the rising edge for in-order comparison.
// Config   : honours OUT_REG_EN (one extra entry of buffering in oreg).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbitrated_fifos;

    localparam int c_N  = 4;
    localparam int c_W  = 8;
    localparam int c_D  = 4;
    localparam int c_TW = 2;
`ifdef OUT_REG_EN
    localparam int c_CAP = c_D + 1;
`else
    localparam int c_CAP = c_D;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_arbitrated_fifos_if #(.NUM_FIFOS(c_N), .WIDTH(c_W), .TAGWIDTH(c_TW)) bus ();

    rr_arbitrated_fifos #(
        .NUM_FIFOS (c_N),
        .WIDTH     (c_W),
        .DEPTH     (c_D),
        .TAGWIDTH  (c_TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q_data[$];
    logic [1:0] q_tag[$];
    logic [3:0] q_gnt[$];
    logic [7:0] e_data[$];
    logic [1:0] e_tag[$];
    logic [3:0] e_gnt[$];

    // Transfer / grant monitor, sampled 2 time units after the falling edge
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (bus.out_vld && bus.out_rdy) begin
                q_data.push_back(bus.data_out);
                q_tag.push_back(bus.out_tag);
            end
            if (bus.gnt != 4'b0000) begin
                q_gnt.push_back(bus.gnt);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_q();
        q_data.delete(); q_tag.delete(); q_gnt.delete();
        e_data.delete(); e_tag.delete(); e_gnt.delete();
    endtask

    task automatic compare_streams(input string tag);
        check_eq({tag, "_n_out"}, 32'(q_data.size()), 32'(e_data.size()));
        for (int i = 0; i < e_data.size(); i++) begin
            if (i < q_data.size()) begin
                check_eq({tag, "_data"}, 32'(q_data[i]), 32'(e_data[i]));
                check_eq({tag, "_tag"}, 32'(q_tag[i]), 32'(e_tag[i]));
            end
        end
        check_eq({tag, "_n_gnt"}, 32'(q_gnt.size()), 32'(e_gnt.size()));
        for (int i = 0; i < e_gnt.size(); i++) begin
            if (i < q_gnt.size()) begin
                check_eq({tag, "_gnt"}, 32'(q_gnt[i]), 32'(e_gnt[i]));
            end
        end
    endtask

    task automatic wait_vld(input int max_cyc);
        int k;
        k = 0;
        #1;
        while (!bus.out_vld && k < max_cyc) begin
            cyc();
            #1;
            k++;
        end
        check_eq("wait_vld", 32'(bus.out_vld), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int full_seen;
        bus.push         = '0;
        bus.flat_data_in = '0;
        bus.out_rdy      = 1'b1;
        rst              = 1'b1;

        // ---------------- reset then idle ----------------
        cyc();
        rst = 1'b0;
        #1;
        check_eq("rst_data", 32'(bus.data_out), 32'h0);
        check_eq("rst_tag", 32'(bus.out_tag), 32'h0);
        check_eq("rst_gnt", 32'(bus.gnt), 32'h0);
        check_eq("rst_full", 32'(bus.full), 32'h0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            #1;
            check_eq("idle_vld", 32'(bus.out_vld), 32'd0);
            check_eq("idle_empty", 32'(bus.empty), 32'hF);
            check_eq("idle_err", 32'(bus.err_ovf), 32'd0);
        end

        // ---------------- round-robin ----------------
        clear_q();
        cyc(); bus.push = 4'b1111; bus.flat_data_in = 32'h43322110;
        cyc(); bus.push = 4'b0001; bus.flat_data_in = 32'h00000011;
        cyc(); bus.push = 4'b0000; bus.flat_data_in = 32'h0;
        repeat (10) cyc();
        e_data = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h11};
        e_tag  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        e_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        compare_streams("rr");

        // ---------------- backpressure ----------------
        // rr now points at ch1; a ch1 push during the stall must not steal
        // the already-presented ch2 entry.
        clear_q();
        cyc(); bus.out_rdy = 1'b0; bus.push = 4'b0100; bus.flat_data_in = 32'h00A50000;
        cyc(); bus.push = 4'b0000; bus.flat_data_in = 32'h0;
        wait_vld(8);
        bus.push = 4'b0010; bus.flat_data_in = 32'h00007700;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_vld", 32'(bus.out_vld), 32'd1);
            check_eq("bp_data", 32'(bus.data_out), 32'hA5);
            check_eq("bp_tag", 32'(bus.out_tag), 32'd2);
            check_eq("bp_gnt", 32'(bus.gnt), 32'h0);
            cyc();
            bus.push = 4'b0000; bus.flat_data_in = 32'h0;
            #1;
        end
        bus.out_rdy = 1'b1;
        repeat (8) cyc();
        e_data = '{8'hA5, 8'h77};
        e_tag  = '{2'd2, 2'd1};
        e_gnt  = '{4'b0100, 4'b0010};
        compare_streams("bp");

        // ---------------- full and overflow ----------------
        clear_q();
        cyc(); bus.out_rdy = 1'b0;
        for (int v = 1; v <= c_CAP; v++) begin
            bus.push = 4'b0010; bus.flat_data_in = 32'(v) << 8;
            cyc();
        end
        bus.push = 4'b0000; bus.flat_data_in = 32'h0;
        #1;
        check_eq("ovf_full1", 32'(bus.full[1]), 32'd1);
        check_eq("ovf_err_before", 32'(bus.err_ovf), 32'd0);
        bus.push = 4'b0010; bus.flat_data_in = 32'(c_CAP + 1) << 8;
        cyc();
        bus.push = 4'b0000; bus.flat_data_in = 32'h0;
        #1;
        check_eq("ovf_err_set", 32'(bus.err_ovf), 32'd1);
        check_eq("ovf_full_hold", 32'(bus.full[1]), 32'd1);
        bus.out_rdy = 1'b1;
        repeat (10) cyc();
        #1;
        check_eq("ovf_err_sticky", 32'(bus.err_ovf), 32'd1);
        check_eq("ovf_drained", 32'(bus.empty), 32'hF);
        for (int v = 1; v <= c_CAP; v++) begin
            e_data.push_back(8'(v));
            e_tag.push_back(2'd1);
            e_gnt.push_back(4'b0010);
        end
        compare_streams("ovf");

        // ---------------- wrap-around on ch3 ----------------
        clear_q();
        full_seen = 0;
        cyc();
        for (int v = 0; v < 10; v++) begin
            bus.push = 4'b1000; bus.flat_data_in = 32'(v) << 24;
            cyc();
            #1;
            if (bus.full != 4'b0000) full_seen++;
        end
        bus.push = 4'b0000; bus.flat_data_in = 32'h0;
        repeat (6) cyc();
        check_eq("wrap_full_seen", 32'(full_seen), 32'd0);
        for (int v = 0; v < 10; v++) begin
            e_data.push_back(8'(v));
            e_tag.push_back(2'd3);
            e_gnt.push_back(4'b1000);
        end
        compare_streams("wrap");

        // ---------------- reset mid-operation ----------------
        // Move rr to 2 via one ch1 pop, then stall with 3 entries in ch0.
        cyc(); bus.push = 4'b0010; bus.flat_data_in = 32'h00009900;
        cyc(); bus.push = 4'b0000; bus.flat_data_in = 32'h0;
        repeat (4) cyc();
        bus.out_rdy = 1'b0;
        for (int v = 0; v < 3; v++) begin
            bus.push = 4'b0001; bus.flat_data_in = 32'(8'hC0 + v);
            cyc();
        end
        bus.push = 4'b0000; bus.flat_data_in = 32'h0;
        cyc();
        #1;
        check_eq("mid_pre_vld", 32'(bus.out_vld), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check_eq("mid_vld", 32'(bus.out_vld), 32'd0);
        check_eq("mid_empty", 32'(bus.empty), 32'hF);
        check_eq("mid_data", 32'(bus.data_out), 32'h0);
        check_eq("mid_tag", 32'(bus.out_tag), 32'h0);
        check_eq("mid_gnt", 32'(bus.gnt), 32'h0);
        check_eq("mid_err", 32'(bus.err_ovf), 32'd0);
        // rr must be back at 0: grants start with ch0.
        clear_q();
        bus.out_rdy = 1'b1;
        bus.push = 4'b1111; bus.flat_data_in = 32'hD3D2D1D0;
        cyc();
        bus.push = 4'b0000; bus.flat_data_in = 32'h0;
        repeat (8) cyc();
        e_data = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        e_tag  = '{2'd0, 2'd1, 2'd2, 2'd3};
        e_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        compare_streams("mid_rr");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
